// File: rtl/sqrt_pkg.sv
// Shared types and default sizes for the square-root scheduler.
package sqrt_pkg;

  localparam int NBITSIN_DEF    = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    STOP    = 3'd3,
    CAPTURE = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

endpackage

// File: rtl/sqrt_sched_if.sv
// Operand and result handshake bundle for sqrt_sched.
// slave is the scheduler side, master is the upstream/downstream side.
interface sqrt_sched_if
  import sqrt_pkg::*;
#(
  parameter int NBITSIN = NBITSIN_DEF
);

  logic [NBITSIN-1:0]   in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [NBITSIN/2-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/sqrt_fifo.sv
// Synchronous operand FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate count. DEPTH must be a power of
// two and at least 2.
module sqrt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rp[AW-1:0]];

  // Pointer update; a simultaneous push and pop moves both and keeps occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + (AW+1)'(1);
      if (rd_en) rp <= rp + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty hides stale entries.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sqrt_sched.sv
// Square-root core scheduler: buffers operands, sequences one core
// operation at a time (start pulse, fixed run time, stop pulse), captures
// the root and offers it downstream.
// Optional feature: define SQRT_SCHED_CHECK_EN to compile in a result
// checker that raises the sticky chk_err flag when r*r <= x < (r+1)^2 fails.
module sqrt_sched
  import sqrt_pkg::*;
#(
  parameter int NBITSIN    = NBITSIN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  sqrt_sched_if.slave          bus,
  output logic                 core_start,
  output logic                 core_stop,
  output logic [NBITSIN-1:0]   core_xin,
  input  logic [NBITSIN/2-1:0] core_sqrt,
  output logic                 chk_err
);

  localparam int HW = NBITSIN / 2;
  localparam int CW = $clog2(HW);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic               run_done;
  logic [NBITSIN-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               out_valid;
  logic [HW-1:0]      out_data_q;

  assign bus.in_ready  = !fifo_full;
  assign push          = bus.in_valid && !fifo_full;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign run_done      = (cnt == CW'(HW - 1));

  sqrt_fifo #(
    .WIDTH (NBITSIN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one operand walks through the full sequence at a time.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (run_done) state_nxt = STOP;
      STOP:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUTPUT;
      OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; the head is popped on the IDLE->START transition.
  always_comb begin
    pop        = 1'b0;
    core_start = 1'b0;
    core_stop  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:    pop        = !fifo_empty;
      START:   core_start = 1'b1;
      STOP:    core_stop  = 1'b1;
      OUTPUT:  out_valid  = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, run counter and result capture.
  // core_xin only changes on a pop, so it holds from START through CAPTURE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_xin   <= '0;
      cnt        <= '0;
      out_data_q <= '0;
    end else begin
      if (pop) core_xin <= fifo_dout;
      if (state == START)    cnt <= '0;
      else if (state == RUN) cnt <= cnt + CW'(1);
      if (state == CAPTURE) out_data_q <= core_sqrt;
    end
  end

`ifdef SQRT_SCHED_CHECK_EN
  // Two guard bits keep (r+1)^2 from overflowing for r = 2^HW - 1.
  function automatic logic root_ok(input logic [NBITSIN-1:0] x,
                                   input logic [HW-1:0]      r);
    logic [NBITSIN+1:0] rr;
    logic [NBITSIN+1:0] rp1;
    logic [NBITSIN+1:0] xx;
    rr  = {{(HW+2){1'b0}}, r};
    rp1 = rr + (NBITSIN+2)'(1);
    xx  = {2'b00, x};
    return ((rr * rr) <= xx) && (xx < (rp1 * rp1));
  endfunction

  logic chk_err_q;
  assign chk_err = chk_err_q;

  // Sticky check of the core result while it is being captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) chk_err_q <= 1'b0;
    else if ((state == CAPTURE) && !root_ok(core_xin, core_sqrt)) chk_err_q <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed bench for sqrt_sched with a behavioural square-root core.
module tb_sqrt_sched;

  logic        clock;
  logic        reset;
  logic        core_start;
  logic        core_stop;
  logic [31:0] core_xin;
  logic [15:0] core_sqrt;
  logic        chk_err;
  logic        force_bad;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_hs = 0;

  sqrt_sched_if #(.NBITSIN(32)) bus ();

  sqrt_sched #(
    .NBITSIN    (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .core_start (core_start),
    .core_stop  (core_stop),
    .core_xin   (core_xin),
    .core_sqrt  (core_sqrt),
    .chk_err    (chk_err)
  );

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = 16'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (({16'd0, t} * {16'd0, t}) <= x) r = t;
    end
    return r;
  endfunction

  // Core model: correct root unless deliberately corrupted.
  assign core_sqrt = force_bad ? 16'd350 : isqrt32(core_xin);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (core_start) n_start <= n_start + 1;
    if (bus.out_valid && bus.out_ready) n_hs <= n_hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] x);
    int n;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("push_accept", 64'(n < 200), 64'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [15:0] r);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("result_arrives", 64'(n < 200), 64'd1);
    r = bus.out_data;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] r;
    int start_k, stop_k, valid_k, starts_seen;
    logic [31:0] xin_at_stop;

    force_bad     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready",   64'(bus.in_ready),  64'd1);
    chk("rst_out_valid",  64'(bus.out_valid), 64'd0);
    chk("rst_out_data",   64'(bus.out_data),  64'd0);
    chk("rst_core_start", 64'(core_start),    64'd0);
    chk("rst_core_stop",  64'(core_stop),     64'd0);
    chk("rst_core_xin",   64'(core_xin),      64'd0);
    chk("rst_chk_err",    64'(chk_err),       64'd0);
    @(negedge clock) reset = 1'b1;

    // Single operand, latency and pulse spacing.
    bus.out_ready = 1'b1;
    push(32'd123456);
    start_k = -1; stop_k = -1; valid_k = -1; starts_seen = 0; xin_at_stop = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (core_start) begin
        starts_seen++;
        if (start_k < 0) start_k = k;
      end
      if (core_stop && stop_k < 0) begin
        stop_k = k;
        xin_at_stop = core_xin;
      end
      if (bus.out_valid) begin
        valid_k = k;
        break;
      end
    end
    chk("lat_start_edge",  64'(start_k),          64'd1);
    chk("lat_stop_gap",    64'(stop_k - start_k), 64'd17);
    chk("lat_valid_edge",  64'(valid_k),          64'd20);
    chk("lat_start_count", 64'(starts_seen),      64'd1);
    chk("xin_hold",        64'(xin_at_stop),      64'd123456);
    chk("root_123456",     64'(bus.out_data),     64'd351);
    @(posedge clock);
    #1;
    chk("valid_drop", 64'(bus.out_valid), 64'd0);

    // Extremes of the operand range.
    push(32'd0);
    push(32'hFFFF_FFFF);
    get_result(r);
    chk("root_0", 64'(r), 64'd0);
    get_result(r);
    chk("root_max", 64'(r), 64'd65535);
    chk("chk_err_clean", 64'(chk_err), 64'd0);

    // Fill the FIFO under backpressure, then drain in order.
    bus.out_ready = 1'b0;
    push(32'd1);
    push(32'd4);
    push(32'd9);
    push(32'd16);
    push(32'd25);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 60 && !bus.out_valid; k++) begin
      @(posedge clock);
      #1;
    end
    chk("bp_valid",     64'(bus.out_valid), 64'd1);
    chk("bp_first",     64'(bus.out_data),  64'd1);
    repeat (10) @(posedge clock);
    #1;
    chk("hold_valid",   64'(bus.out_valid), 64'd1);
    chk("hold_data",    64'(bus.out_data),  64'd1);
    chk("hold_starts",  64'(n_start),       64'd4);
    chk("hold_full",    64'(bus.in_ready),  64'd0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      get_result(r);
      chk("drain_order", 64'(r), 64'(i));
    end
    chk("drain_empty_ready", 64'(bus.in_ready), 64'd1);
    chk("hs_total", 64'(n_hs), 64'd8);

    // Reset while an operand is running and another is queued.
    push(32'd1000);
    push(32'd2000);
    repeat (6) @(posedge clock);
    #1;
    chk("run_xin", 64'(core_xin), 64'd1000);
    reset = 1'b0;
    #1;
    chk("mid_rst_start",    64'(core_start),    64'd0);
    chk("mid_rst_stop",     64'(core_stop),     64'd0);
    chk("mid_rst_valid",    64'(bus.out_valid), 64'd0);
    chk("mid_rst_data",     64'(bus.out_data),  64'd0);
    chk("mid_rst_xin",      64'(core_xin),      64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready),  64'd1);
    @(negedge clock) reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("abandon_hs",     64'(n_hs),          64'd8);
    chk("abandon_starts", 64'(n_start),       64'd9);
    chk("abandon_valid",  64'(bus.out_valid), 64'd0);

    // Corrupted core result.
    force_bad = 1'b1;
    push(32'd123456);
    get_result(r);
    chk("bad_root", 64'(r), 64'd350);
`ifdef SQRT_SCHED_CHECK_EN
    chk("chk_err_set", 64'(chk_err), 64'd1);
    force_bad = 1'b0;
    push(32'd16);
    get_result(r);
    chk("good_after_bad", 64'(r), 64'd4);
    chk("chk_err_sticky", 64'(chk_err), 64'd1);
    @(negedge clock) reset = 1'b0;
    #1;
    chk("chk_err_reset", 64'(chk_err), 64'd0);
    @(negedge clock) reset = 1'b1;
`else
    chk("chk_err_tied", 64'(chk_err), 64'd0);
    force_bad = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
